// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, FSM encoding and BCD digit sizing shared by the sequential ALU
package ula_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_MOD = 3'd7;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CONV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  function automatic int digits_f(input int width);
    longint v;
    int d;
    v = (longint'(1) << (2 * width)) - 1;
    d = 1;
    for (int i = 0; i < 20; i++)
      if (v >= 10) begin
        v = v / 10;
        d++;
      end
    return d;
  endfunction
endpackage

// File: rtl/ula_sequencial_if.sv
// ula_sequencial_if: operand request / result bundle of the sequential ALU
interface ula_sequencial_if #(parameter int WIDTH = 4) ();
  import ula_pkg::*;
  localparam int DIGITS = digits_f(WIDTH);
  logic                  start;
  logic [WIDTH-1:0]      A_in;
  logic [WIDTH-1:0]      B_in;
  logic                  Cin;
  logic [2:0]            OP_sel;
  logic                  busy;
  logic                  done;
  logic [2*WIDTH-1:0]    result;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  is_negative;
  logic                  LED_Cout;
  logic                  LED_OV;
  logic                  LED_Z;
  logic                  LED_ERR;
  modport master (output start, A_in, B_in, Cin, OP_sel,
                  input busy, done, result, bcd_out, is_negative, LED_Cout, LED_OV, LED_Z, LED_ERR);
  modport slave (input start, A_in, B_in, Cin, OP_sel,
                 output busy, done, result, bcd_out, is_negative, LED_Cout, LED_OV, LED_Z, LED_ERR);
endinterface

// File: rtl/ula_sequencial_bcd.sv
// bin_para_bcd_seq: double-dabble converter, one input bit shifted in per cycle after load
module bin_para_bcd_seq #(
  parameter int WIDTH_IN = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH_IN-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(WIDTH_IN + 1);
  logic [WIDTH_IN-1:0] sh_q, sh_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d;
  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (load) begin
      sh_d   = bin_in;
      bcd_d  = '0;
      cnt_d  = CW'(WIDTH_IN);
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d   = sh_q << 1;
      bcd_d  = {adj[4*DIGITS-2:0], sh_q[WIDTH_IN-1]};
      cnt_d  = cnt_q - CW'(1);
      busy_d = cnt_q != CW'(1);
      done_d = cnt_q == CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
endmodule

// File: rtl/ula_sequencial.sv
// ula_sequencial: multi-cycle ALU with iterative mul/div and sequential BCD display conversion
module ula_sequencial
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  ula_sequencial_if.slave bus
);
  localparam int DIGITS = digits_f(WIDTH);
  localparam int W2     = 2 * WIDTH;
  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic                cin_q, cin_d;
  logic [2:0]          op_q, op_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [W2-1:0]       acc_q, acc_d, step, res, mag;
  logic [W2-1:0]       result_q, result_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, conv_bcd;
  logic                neg_q, neg_d, cout_q, cout_d, ov_q, ov_d, z_q, z_d, err_q, err_d;
  logic [WIDTH:0]      sum, dif, t, nmag;
  logic [WIDTH-1:0]    rem;
  logic                err, iter, last, ge, bsel, upd, conv_load, conv_busy, conv_done;
  always_comb begin
    sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    dif  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
    err  = (op_q == OP_DIV || op_q == OP_MOD) && b_q == '0;
    iter = op_q == OP_MUL || ((op_q == OP_DIV || op_q == OP_MOD) && !err);
    last = !iter || cnt_q == 4'(WIDTH - 1);
    // restoring division: acc holds {partial remainder, dividend/quotient}
    t    = acc_q[W2-1:WIDTH-1];
    ge   = t >= {1'b0, b_q};
    rem  = ge ? WIDTH'(t - {1'b0, b_q}) : t[WIDTH-1:0];
    bsel = |(b_q & (WIDTH'(1) << cnt_q));
    step = op_q == OP_MUL ? acc_q + (bsel ? (W2'(a_q) << cnt_q) : '0)
                          : {rem, acc_q[WIDTH-2:0], ge};
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (state_q == S_IDLE && bus.start) begin
      state_d = S_EXEC;
      a_d     = bus.A_in;
      b_d     = bus.B_in;
      cin_d   = bus.Cin;
      op_d    = bus.OP_sel;
      cnt_d   = '0;
      acc_d   = bus.OP_sel == OP_MUL ? '0 : W2'(bus.A_in);
    end else if (state_q == S_EXEC) begin
      acc_d   = iter ? step : acc_q;
      cnt_d   = cnt_q + 4'd1;
      state_d = last ? S_CONV : S_EXEC;
    end else if (state_q == S_CONV)
      state_d = conv_done ? S_DONE : S_CONV;
    else if (state_q == S_DONE)
      state_d = S_IDLE;
    // one extra magnitude bit so the most negative difference displays correctly
    nmag = dif[WIDTH-1] ? ~{1'b1, dif[WIDTH-1:0]} + (WIDTH+1)'(1) : {1'b0, dif[WIDTH-1:0]};
    res  = op_q == OP_ADD ? W2'(sum[WIDTH-1:0]) :
           op_q == OP_SUB ? W2'(dif[WIDTH-1:0]) :
           op_q == OP_AND ? W2'(a_q & b_q) :
           op_q == OP_OR  ? W2'(a_q | b_q) :
           op_q == OP_XOR ? W2'(a_q ^ b_q) :
           err ? '0 : acc_d;
    mag  = op_q == OP_SUB ? W2'(nmag) :
           err ? '0 :
           op_q == OP_DIV ? W2'(acc_d[WIDTH-1:0]) :
           op_q == OP_MOD ? W2'(acc_d[W2-1:WIDTH]) : res;
    upd      = state_q == S_CONV && conv_done;
    result_d = upd ? res : result_q;
    bcd_d    = upd ? conv_bcd : bcd_q;
    neg_d    = upd ? op_q == OP_SUB && dif[WIDTH-1] : neg_q;
    cout_d   = upd ? (op_q == OP_ADD ? sum[WIDTH] : op_q == OP_SUB && dif[WIDTH]) : cout_q;
    ov_d     = upd ? (op_q == OP_ADD ? (a_q[WIDTH-1] & b_q[WIDTH-1] & ~sum[WIDTH-1]) |
                                       (~a_q[WIDTH-1] & ~b_q[WIDTH-1] & sum[WIDTH-1]) :
                      op_q == OP_SUB ? (a_q[WIDTH-1] & ~b_q[WIDTH-1] & ~dif[WIDTH-1]) |
                                       (~a_q[WIDTH-1] & b_q[WIDTH-1] & dif[WIDTH-1]) : 1'b0) : ov_q;
    z_d      = upd ? mag == '0 && !err : z_q;
    err_d    = upd ? err : err_q;
  end
  assign conv_load = state_q == S_EXEC && last;
  bin_para_bcd_seq #(.WIDTH_IN(W2), .DIGITS(DIGITS)) u_bcd (
    .clk(clk), .rst_n(rst_n), .load(conv_load), .bin_in(mag),
    .busy(conv_busy), .done(conv_done), .bcd(conv_bcd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      cout_q   <= 1'b0;
      ov_q     <= 1'b0;
      z_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      cout_q   <= cout_d;
      ov_q     <= ov_d;
      z_q      <= z_d;
      err_q    <= err_d;
    end
  assign bus.busy        = state_q == S_EXEC || conv_busy || conv_done;
  assign bus.done        = state_q == S_DONE;
  assign bus.result      = result_q;
  assign bus.bcd_out     = bcd_q;
  assign bus.is_negative = neg_q;
  assign bus.LED_Cout    = cout_q;
  assign bus.LED_OV      = ov_q;
  assign bus.LED_Z       = z_q;
  assign bus.LED_ERR     = err_q;
endmodule

// File: tb/tb_ula_sequencial.sv
// tb_ula_sequencial: directed vectors against a behavioural arithmetic model, checked every cycle
module tb_ula_sequencial;
  localparam int W = 4;
  localparam int M = 1 << W;
  typedef struct packed {
    logic [7:0]  res;
    logic [11:0] bcd;
    logic        neg, co, ov, z, err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, checks = 0, failures = 0;
  int   acc_n = 0, done_n = -1, last_done = -100;
  logic active = 1'b0, ed, eb;
  exp_t pend = '0, cur = '0, e;
  ula_sequencial_if #(.WIDTH(W)) bus ();
  ula_sequencial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input int op, input int a, input int b, input int cin);
    exp_t x = '0;
    int sa = a >= M / 2 ? a - M : a;
    int sb = b >= M / 2 ? b - M : b;
    int r = 0, mag = 0, s = 0;
    case (op)
      0: begin
        r = a + b + cin; x.co = r >= M; r = r % M; mag = r;
        s = sa + sb + cin; x.ov = s > M / 2 - 1 || s < -M / 2;
      end
      1: begin
        r = a - b - cin; x.co = r < 0; if (r < 0) r += M;
        s = sa - sb - cin; x.ov = s > M / 2 - 1 || s < -M / 2;
        x.neg = r >= M / 2; mag = x.neg ? M - r : r;
      end
      2: begin r = a & b; mag = r; end
      3: begin r = a | b; mag = r; end
      4: begin r = a ^ b; mag = r; end
      5: begin r = a * b; mag = r; end
      default:
        if (b == 0) x.err = 1'b1;
        else begin r = (a % b) * M + a / b; mag = op == 6 ? a / b : a % b; end
    endcase
    x.res = 8'(r);
    x.z   = mag == 0 && !x.err;
    x.bcd = {4'(mag / 100 % 10), 4'(mag / 10 % 10), 4'(mag % 10)};
    return x;
  endfunction

  function automatic int lat(input int op, input int b);
    return ((op == 5 || (op >= 6 && b != 0)) ? W : 1) + 2 * W + 1;
  endfunction

  always @(negedge clk) begin
    ed = rst_n && active && cyc == done_n;
    eb = rst_n && active && cyc >= acc_n && cyc < done_n;
    if (!rst_n) begin cur = '0; active = 1'b0; end
    if (ed) begin cur = pend; active = 1'b0; end
    if (bus.done) last_done = cyc;
    chk("busy", bus.busy, eb);
    chk("done", bus.done, ed);
    chk("result", bus.result, cur.res);
    chk("bcd_out", bus.bcd_out, cur.bcd);
    chk("is_negative", bus.is_negative, cur.neg);
    chk("LED_Cout", bus.LED_Cout, cur.co);
    chk("LED_OV", bus.LED_OV, cur.ov);
    chk("LED_Z", bus.LED_Z, cur.z);
    chk("LED_ERR", bus.LED_ERR, cur.err);
  end

  task automatic launch(input int op, input int a, input int b, input int cin);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.OP_sel = 3'(op); bus.A_in = 4'(a); bus.B_in = 4'(b); bus.Cin = 1'(cin);
    acc_n = cyc + 1; done_n = acc_n + lat(op, b); pend = model(op, a, b, cin); active = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.A_in = ~bus.A_in; bus.B_in = 4'(b + 3); bus.Cin = ~bus.Cin; bus.OP_sel = bus.OP_sel ^ 3'd5;
  endtask

  task automatic finish_op();
    while (cyc < done_n) begin @(posedge clk); #2; end
    #4;
  endtask

  task automatic run(input int op, input int a, input int b, input int cin);
    launch(op, a, b, cin);
    finish_op();
  endtask

  int vec [11][4] = '{'{2, 12, 10, 0}, '{3, 12, 3, 0}, '{4, 15, 5, 0}, '{0, 8, 8, 0},
                      '{1, 8, 0, 1}, '{1, 0, 0, 1}, '{6, 15, 1, 0}, '{7, 15, 7, 0},
                      '{5, 8, 13, 0}, '{0, 0, 0, 0}, '{7, 3, 9, 1}};

  initial begin
    bus.start = 1'b0; bus.A_in = '0; bus.B_in = '0; bus.Cin = 1'b0; bus.OP_sel = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_result", bus.result, 0);
    chk("rst_LED_Z", bus.LED_Z, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    e = model(0, 7, 5, 1);
    chk("model_add_res", e.res, 'h0D);
    chk("model_add_ov", e.ov, 1);
    e = model(7, 13, 4, 0);
    chk("model_mod_bcd", e.bcd, 'h001);
    run(0, 7, 5, 1);
    chk("add_res", bus.result, 'h0D); chk("add_bcd", bus.bcd_out, 'h013);
    chk("add_cout", bus.LED_Cout, 0); chk("add_ov", bus.LED_OV, 1); chk("add_z", bus.LED_Z, 0);
    chk("add_latency", last_done - acc_n, 10);
    run(1, 3, 5, 0);
    chk("sub_res", bus.result, 'h0E); chk("sub_neg", bus.is_negative, 1);
    chk("sub_bcd", bus.bcd_out, 'h002); chk("sub_cout", bus.LED_Cout, 1); chk("sub_ov", bus.LED_OV, 0);
    run(1, 0, 8, 0);
    chk("sub_min_res", bus.result, 'h08); chk("sub_min_neg", bus.is_negative, 1);
    chk("sub_min_bcd", bus.bcd_out, 'h008); chk("sub_min_ov", bus.LED_OV, 1);
    run(5, 15, 15, 0);
    chk("mul_res", bus.result, 'hE1); chk("mul_bcd", bus.bcd_out, 'h225);
    chk("mul_latency", last_done - acc_n, 13);
    run(5, 0, 9, 0);
    chk("mul_zero_z", bus.LED_Z, 1);
    run(6, 13, 4, 0);
    chk("div_res", bus.result, 'h13); chk("div_bcd", bus.bcd_out, 'h003);
    run(7, 13, 4, 0);
    chk("mod_bcd", bus.bcd_out, 'h001);
    run(6, 9, 0, 0);
    chk("dz_err", bus.LED_ERR, 1); chk("dz_res", bus.result, 0);
    chk("dz_bcd", bus.bcd_out, 0); chk("dz_z", bus.LED_Z, 0);
    chk("dz_latency", last_done - acc_n, 10);
    run(0, 2, 2, 0);
    chk("err_clear", bus.LED_ERR, 0); chk("after_err_res", bus.result, 4);
    foreach (vec[i]) run(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
    launch(5, 7, 9, 0);
    repeat (2) begin @(posedge clk); #2; end
    bus.start = 1'b1; bus.OP_sel = 3'd0; bus.A_in = 4'd1; bus.B_in = 4'd1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    finish_op();
    chk("ignored_start_res", bus.result, 'h3F);
    chk("ignored_start_latency", last_done - acc_n, 13);
    repeat (15) @(posedge clk);
    launch(5, 11, 6, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", bus.result, 0); chk("async_rst_bcd", bus.bcd_out, 0);
    chk("async_rst_busy", bus.busy, 0); chk("async_rst_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    run(0, 3, 4, 0);
    chk("post_rst_res", bus.result, 7); chk("post_rst_bcd", bus.bcd_out, 'h007);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
